// File: rtl/proc_pkg.sv
// Shared constants for the mini processor system: opcodes, the Done latency
// each opcode must show, and the instruction sequencer state encoding.
package proc_pkg;

  // Opcode field, bits [7:6] of an instruction word
  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // Done latency in cycles, counted from the cycle Run is high
  localparam int LAT_SHORT = 1;
  localparam int LAT_LONG  = 3;

  // Sequencer states, plain constants so older tools can read them
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  // Latency the core must show for a given opcode
  function automatic int req_latency(input logic [1:0] op);
    int lat;
    case (op)
      OP_ADD, OP_SUB: lat = LAT_LONG;
      default:        lat = LAT_SHORT;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the instruction sequencer: synchronous write,
// asynchronous read, deliberately left without reset so a loaded program
// survives a sequencer reset.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port; the word is visible on the read port from the next cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issuing master for the 8-bit mini processor core. Steps through a stored
// program, pulses Run with one instruction at a time, waits for Done,
// captures Bus and checks that Done arrived with the opcode's latency.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [7:0]    DIN,
  output logic          Run,
  input  logic          Done,
  input  logic [7:0]    Bus,
  output logic          busy,
  output logic          prog_done,
  output logic [7:0]    last_bus,
  output logic [AW:0]   instr_cnt,
  output logic          timeout_err,
  output logic          lat_err
);

  // Wait counter must hold TIMEOUT and the longest required latency
  localparam int CW = (TIMEOUT > 3) ? $clog2(TIMEOUT + 1) : 2;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [AW:0]   len_q;
  logic [1:0]    op_q;
  logic [CW-1:0] wcnt;
  logic [GW-1:0] gcnt;
  logic [7:0]    mem_rd;
  logic [AW:0]   pc_next_ext;
  logic          last_instr;
  logic          start_ok;
  logic          mem_we;

  // Writes are dropped while a program is running
  assign mem_we = wr_en & ~busy;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (pc),
    .rdata (mem_rd)
  );

  // Outputs decoded straight from state so reset clears them immediately
  assign Run       = (state == ST_ISSUE);
  assign DIN       = Run ? mem_rd : 8'h00;
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_GAP);
  assign prog_done = (state == ST_FINISH);

  // pc+1 widened so it compares against prog_len up to DEPTH
  assign pc_next_ext = {1'b0, pc} + (AW + 1)'(1);
  assign last_instr  = (pc_next_ext == len_q);
  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_ERROR));

  // Opcode of the instruction in flight, used only for the latency check
  always_ff @(posedge clk) begin
    if (state == ST_ISSUE) begin
      op_q <= mem_rd[7:6];
    end
  end

  // Sequencer FSM with its counters, capture register and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      len_q       <= '0;
      wcnt        <= '0;
      gcnt        <= '0;
      last_bus    <= 8'h00;
      instr_cnt   <= '0;
      timeout_err <= 1'b0;
      lat_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          // A start from ERROR also clears the sticky flags and rewinds pc
          if (start_ok) begin
            len_q       <= prog_len;
            pc          <= '0;
            instr_cnt   <= '0;
            timeout_err <= 1'b0;
            lat_err     <= 1'b0;
            state       <= (prog_len == '0) ? ST_FINISH : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // First WAIT cycle is latency 1
          wcnt  <= CW'(1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Done) begin
            last_bus  <= Bus;
            instr_cnt <= instr_cnt + (AW + 1)'(1);
            pc        <= pc_next_ext[AW-1:0];
            gcnt      <= GW'(1);
            // Wrong latency is flagged but the result is still accepted
            if (int'(wcnt) != req_latency(op_q)) begin
              lat_err <= 1'b1;
            end
            state <= last_instr ? ST_FINISH : ST_GAP;
          end else if (int'(wcnt) >= TIMEOUT) begin
            timeout_err <= 1'b1;
            state       <= ST_ERROR;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (int'(gcnt) >= GAP) begin
            state <= ST_ISSUE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a behavioural core responder executes the
// issued words, single-instruction vectors are table driven, and the
// multi-cycle corner cases are written out as hand sequences.
module tb_instr_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic [7:0]    DIN;
  logic          Run;
  logic          Done;
  logic [7:0]    Bus;
  logic          busy;
  logic          prog_done;
  logic [7:0]    last_bus;
  logic [AW:0]   instr_cnt;
  logic          timeout_err;
  logic          lat_err;

  int tests = 0;
  int fails = 0;

  // Responder controls
  int   ovr_lat = 0;
  logic no_done = 1'b0;

  // Monitors
  int         issues = 0;
  int         done_pulses = 0;
  logic       cap_pend = 1'b0;
  logic [7:0] busq [$];

  instr_sequencer #(
    .DEPTH   (16),
    .AW      (AW),
    .TIMEOUT (15),
    .GAP     (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .prog_len    (prog_len),
    .start       (start),
    .DIN         (DIN),
    .Run         (Run),
    .Done        (Done),
    .Bus         (Bus),
    .busy        (busy),
    .prog_done   (prog_done),
    .last_bus    (last_bus),
    .instr_cnt   (instr_cnt),
    .timeout_err (timeout_err),
    .lat_err     (lat_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Core model: executes on Run, answers with Done after the opcode latency
  initial begin
    int         cd;
    logic [1:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] r [8];
    logic [7:0] res;
    Done = 1'b0;
    Bus  = 8'h00;
    cd   = 0;
    res  = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      Done = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd = cd - 1;
          if (cd == 0) begin
            Done = 1'b1;
            Bus  = res;
          end
        end
        if (Run && !no_done) begin
          op = DIN[7:6];
          x  = DIN[5:3];
          y  = DIN[2:0];
          case (op)
            2'b00:   r[x] = r[y];
            2'b01:   r[x] = {5'd0, y};
            2'b10:   r[x] = r[x] + r[y];
            default: r[x] = r[x] - r[y];
          endcase
          res = r[x];
          cd  = (ovr_lat != 0) ? ovr_lat : (op[1] ? 3 : 1);
        end
      end
    end
  end

  // Count issues and prog_done pulses, log last_bus after each Done
  always @(negedge clk) begin
    if (Run) issues <= issues + 1;
    if (prog_done) done_pulses <= done_pulses + 1;
    if (cap_pend) busq.push_back(last_bus);
    cap_pend <= Done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic start_pulse(input logic [AW:0] len);
    prog_len = len;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n;
    n = 0;
    while (prog_done !== 1'b1 && n < maxc) begin
      cyc();
      n++;
    end
    check({name, "_prog_done"}, prog_done, 1);
  endtask

  typedef struct {
    logic [7:0] word;
    int         lat;
    logic [7:0] exp_bus;
    logic       exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int bi, bd, nb;

    // word, responder latency (0 = correct), expected last_bus, expected lat_err
    vecs[0]  = '{8'h45, 0, 8'h05, 1'b0};  // mvi R0,5
    vecs[1]  = '{8'h4B, 0, 8'h03, 1'b0};  // mvi R1,3
    vecs[2]  = '{8'h81, 0, 8'h08, 1'b0};  // add R0,R1
    vecs[3]  = '{8'hC1, 0, 8'h05, 1'b0};  // sub R0,R1
    vecs[4]  = '{8'h10, 0, 8'h05, 1'b0};  // mv  R2,R0
    vecs[5]  = '{8'h5F, 0, 8'h07, 1'b0};  // mvi R3,7
    vecs[6]  = '{8'h9B, 0, 8'h0E, 1'b0};  // add R3,R3
    vecs[7]  = '{8'hCB, 0, 8'hF5, 1'b0};  // sub R1,R3 -> 3-14
    vecs[8]  = '{8'h81, 2, 8'hFA, 1'b1};  // add R0,R1 answered early
    vecs[9]  = '{8'h47, 3, 8'h07, 1'b1};  // mvi R0,7 answered late
    vecs[10] = '{8'hD8, 1, 8'h07, 1'b1};  // sub R3,R0 answered early

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = 8'h00;
    prog_len = '0;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_run", Run, 0);
    check("rst_din", DIN, 0);
    check("rst_busy", busy, 0);
    check("rst_prog_done", prog_done, 0);
    check("rst_last_bus", last_bus, 0);
    check("rst_instr_cnt", instr_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_lat_err", lat_err, 0);
    rst_n = 1'b1;
    cyc();

    // Single-instruction vectors
    for (int i = 0; i < 11; i++) begin
      load(0, vecs[i].word);
      ovr_lat = vecs[i].lat;
      start_pulse(1);
      check($sformatf("vec%0d_din", i), DIN, vecs[i].word);
      wait_done($sformatf("vec%0d", i), 40);
      check($sformatf("vec%0d_last_bus", i), last_bus, vecs[i].exp_bus);
      check($sformatf("vec%0d_lat_err", i), lat_err, vecs[i].exp_lat);
      check($sformatf("vec%0d_instr_cnt", i), instr_cnt, 1);
      ovr_lat = 0;
      cyc();
      check($sformatf("vec%0d_idle_busy", i), busy, 0);
    end

    // Four-instruction program
    load(0, 8'h45);
    load(1, 8'h4B);
    load(2, 8'h81);
    load(3, 8'hC1);
    bi = issues;
    bd = done_pulses;
    nb = busq.size();
    start_pulse(4);
    wait_done("prog4", 60);
    repeat (3) cyc();
    check("prog4_issues", issues - bi, 4);
    check("prog4_done_pulses", done_pulses - bd, 1);
    check("prog4_captures", busq.size() - nb, 4);
    check("prog4_bus0", busq[nb + 0], 8'h05);
    check("prog4_bus1", busq[nb + 1], 8'h03);
    check("prog4_bus2", busq[nb + 2], 8'h08);
    check("prog4_bus3", busq[nb + 3], 8'h05);
    check("prog4_instr_cnt", instr_cnt, 4);
    check("prog4_lat_err", lat_err, 0);

    // Timeout: responder never answers
    no_done = 1'b1;
    load(0, 8'h45);
    bi = issues;
    bd = done_pulses;
    start_pulse(1);
    check("to_issue_run", Run, 1);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      if (j == 15) begin
        check("to_wait15_err", timeout_err, 0);
        check("to_wait15_busy", busy, 1);
      end
      if (j == 16) begin
        check("to_err_set", timeout_err, 1);
        check("to_err_busy", busy, 0);
      end
    end
    repeat (5) cyc();
    check("to_issues", issues - bi, 1);
    check("to_run_low", Run, 0);
    check("to_no_prog_done", done_pulses - bd, 0);
    no_done = 1'b0;
    start_pulse(1);
    check("to_restart_din", DIN, 8'h45);
    wait_done("to_restart", 40);
    check("to_restart_err_clr", timeout_err, 0);
    cyc();

    // start and write during WAIT are both ignored
    load(0, 8'h45);
    load(1, 8'h4B);
    bi = issues;
    bd = done_pulses;
    start_pulse(2);
    cyc();
    check("ign_in_wait", busy, 1);
    start    = 1'b1;
    prog_len = 2;
    wr_en    = 1'b1;
    wr_addr  = 0;
    wr_data  = 8'h47;
    cyc();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done("ign", 40);
    repeat (4) cyc();
    check("ign_issues", issues - bi, 2);
    check("ign_done_pulses", done_pulses - bd, 1);
    check("ign_busy", busy, 0);
    start_pulse(1);
    check("ign_rerun_din", DIN, 8'h45);
    wait_done("ign_rerun", 40);
    cyc();
    check("ign_rerun_bus", last_bus, 8'h05);

    // Empty program
    bi = issues;
    start_pulse(0);
    check("len0_prog_done", prog_done, 1);
    check("len0_run", Run, 0);
    check("len0_instr_cnt", instr_cnt, 0);
    cyc();
    check("len0_pulse_end", prog_done, 0);
    check("len0_issues", issues - bi, 0);

    // Reset while waiting on an add
    load(0, 8'h45);
    load(1, 8'h81);
    start_pulse(2);
    repeat (4) cyc();
    check("rstw_busy_before", busy, 1);
    check("rstw_cnt_before", instr_cnt, 1);
    check("rstw_bus_before", last_bus, 8'h05);
    rst_n = 1'b0;
    #1;
    check("rstw_run", Run, 0);
    check("rstw_busy", busy, 0);
    check("rstw_last_bus", last_bus, 0);
    check("rstw_instr_cnt", instr_cnt, 0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    check("rstw_idle", busy, 0);
    start_pulse(2);
    check("rstw_rerun_din", DIN, 8'h45);
    wait_done("rstw_rerun", 60);
    check("rstw_rerun_cnt", instr_cnt, 2);
    check("rstw_rerun_bus", last_bus, 8'h08);
    check("rstw_rerun_lat", lat_err, 0);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Issuing master for the 8-bit mini processor core. It holds a small program of 8-bit instruction words and drives them onto the core's DIN/Run inputs one at a time.
- Waits for the core's Done strobe after each instruction, captures Bus on Done, and checks that Done arrives with the correct latency for the opcode.
- Sits between the host or load logic and the processor core. It replaces the hand-driven instruction stimulus at the system level.

Parameters:
- DEPTH, 16: program memory entries; must be a power of two.
- AW, 4: address width, log2(DEPTH).
- TIMEOUT, 15: WAIT cycles without Done before the error state is entered.
- GAP, 1: idle cycles (Run=0) inserted after Done before the next issue; minimum 1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  program write strobe.
- wr_addr  in  AW  program write address.
- wr_data  in  8  instruction word {op[7:6], X[5:3], Y[2:0]}.
- prog_len  in  AW+1  number of instructions to run, 0..DEPTH; sampled on start.
- start  in  1  one-cycle start pulse.
- DIN  out  8  instruction to the core.
- Run  out  1  issue strobe to the core.
- Done  in  1  completion strobe from the core.
- Bus  in  8  core result bus.
- busy  out  1  high from the cycle after an accepted start until FINISH or ERROR.
- prog_done  out  1  one-cycle pulse when all instructions have completed.
- last_bus  out  8  Bus value captured on the most recent accepted Done.
- instr_cnt  out  AW+1  instructions completed since the last start.
- timeout_err  out  1  sticky; no Done within TIMEOUT.
- lat_err  out  1  sticky; Done latency mismatched the opcode.

Behaviour:
- Reset (async, Reset=0): every output is 0 (Run, DIN, busy, prog_done, last_bus, instr_cnt, timeout_err, lat_err). State returns to IDLE and pc=0. Program memory contents are not reset.
- Opcodes: 00 mv, 01 mvi (immediate = Y field), 10 add, 11 sub.
- Required Done latency, counted from the ISSUE cycle k:
  - mv/mvi: Done in cycle k+1.
  - add/sub: Done in cycle k+3.
- States: IDLE, ISSUE, WAIT, GAP, FINISH, ERROR.
- IDLE:
  - start=1 with prog_len>0: latch prog_len, clear pc, instr_cnt, timeout_err and lat_err, go to ISSUE. busy=1 from the next cycle.
  - start=1 with prog_len=0: go to FINISH.
- ISSUE: exactly one cycle with Run=1 and DIN=mem[pc]. Latch the opcode, clear the wait counter, go to WAIT. Done seen in this cycle is ignored.
- WAIT: Run=0, DIN=0. The wait counter starts at 1 in cycle k+1.
  - On Done=1: last_bus<=Bus, instr_cnt++, pc++.
  - Also on Done, if the counter ≠ required latency, set lat_err; the instruction is still accepted.
  - Next state: FINISH if the completed instruction was index prog_len-1, else GAP.
  - Counter reaching TIMEOUT with no Done: set timeout_err, go to ERROR.
- GAP: Run=0 for GAP cycles, then ISSUE.
- FINISH: prog_done=1 for one cycle, busy=0, go to IDLE.
- ERROR: busy=0 and Run stays 0. The next start clears timeout_err and restarts from pc=0.
- Ignored inputs:
  - start while busy.
  - Done outside WAIT.
  - wr_en while busy (write dropped); wr_en in IDLE writes mem[wr_addr].
- Write and start in the same IDLE cycle: the write completes before the first ISSUE reads memory, so the new word is used.
- Reset mid-program: Run drops immediately, busy=0, outputs cleared, state IDLE.

Decomposition:
- Shared package/header (proc_pkg):
  - opcode constants OP_MV=2'b00, OP_MVI=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - LAT_SHORT=1, LAT_LONG=3.
  - State encoding for IDLE/ISSUE/WAIT/GAP/FINISH/ERROR.
- One sub-module, seq_prog_mem: DEPTH x 8 synchronous-write, asynchronous-read register array with no reset.

Test Plan:
- Real core attached. Load 0x45 (mvi R0,5), 0x4B (mvi R1,3), 0x81 (add R0,R1), 0xC1 (sub R0,R1); prog_len=4; start.
  -> Run pulses one cycle each; last_bus sequence 5,3,8,5; instr_cnt=4; one prog_done pulse; lat_err=0.
- Responder model never asserts Done, TIMEOUT=15.
  -> timeout_err=1 on the 15th WAIT cycle; state ERROR; Run never reasserts; busy=0.
- Model returns Done at k+2 for 0x81.
  -> lat_err=1; last_bus captured; the program continues to prog_done.
- start pulsed and wr_en to addr 0 with 0x47 during WAIT of a 2-instruction program.
  -> both ignored; exactly 2 issues; rerun uses the original word at addr 0.
- prog_len=0, start.
  -> prog_done one cycle after start; Run stays 0; instr_cnt=0.
- Reset driven low in WAIT of an add.
  -> Run, busy, last_bus and instr_cnt are 0 within the same cycle; after release, start reruns from pc=0.
